mips_multicycle_controller: RTL and testbench

Moore-style control FSM that sequences the shared datapath of the multicycle variant of the 32-bit MIPS processor: one memory port, one ALU, instruction/data registers. It decodes `op`/`funct` from the instruction register, walks each instruction through fetch, decode, execute, memory and writeback states, and drives every mux select and write enable in the datapath. It replaces the single-cycle main decoder and ALU decoder inside the top-level processor.

---
 rtl/mips_multicycle_controller.sv | 163 ++++++++++++++++
 tb/tb_mips_multicycle_controller.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and drives every datapath select and write enable as a Moore function of state.
module mips_multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic [1:0] regdst,
  output logic [1:0] memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11,
    JALEX   = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_LBU  = 6'b100100;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  state_t cur_st, nxt_st;
  logic   pcwrite, branch, irwrite_s, memwrite_s, regwrite_s;

  // Unknown funct falls back to add so the writeback still produces a defined value.
  function automatic logic [2:0] alu_decode(input logic [5:0] f);
    case (f)
      6'b100000: alu_decode = 3'b010;
      6'b100010: alu_decode = 3'b110;
      6'b100100: alu_decode = 3'b000;
      6'b100101: alu_decode = 3'b001;
      6'b101010: alu_decode = 3'b111;
      default:   alu_decode = 3'b010;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) cur_st <= FETCH;
    else       cur_st <= nxt_st;
  end

  always_comb begin
    nxt_st     = FETCH;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    iord       = 1'b0;
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    regwrite_s = 1'b0;
    regdst     = 2'b00;
    memtoreg   = 2'b00;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = 3'b010;
    case (cur_st)
      FETCH: begin
        irwrite_s = 1'b1;
        pcwrite   = 1'b1;
        alusrcb   = 2'b01;
        nxt_st    = DECODE;
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_LBU, OP_SW: nxt_st = MEMADR;
          OP_R:                 nxt_st = RTYPEEX;
          OP_BEQ:               nxt_st = BEQEX;
          OP_ADDI:              nxt_st = ADDIEX;
          OP_J:                 nxt_st = JEX;
          OP_JAL:               nxt_st = JALEX;
          default:              nxt_st = FETCH;
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        if (op == OP_SW) nxt_st = MEMWR;
        else             nxt_st = MEMRD;
      end
      MEMRD: begin
        iord   = 1'b1;
        nxt_st = MEMWB;
      end
      MEMWB: begin
        regwrite_s = 1'b1;
        memtoreg   = (op == OP_LBU) ? 2'b11 : 2'b01;
      end
      MEMWR: begin
        iord       = 1'b1;
        memwrite_s = 1'b1;
      end
      RTYPEEX: begin
        alusrca    = 1'b1;
        alucontrol = alu_decode(funct);
        nxt_st     = RTYPEWB;
      end
      RTYPEWB: begin
        regwrite_s = 1'b1;
        regdst     = 2'b01;
      end
      BEQEX: begin
        alusrca    = 1'b1;
        alucontrol = 3'b110;
        pcsrc      = 2'b01;
        branch     = 1'b1;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        nxt_st  = ADDIWB;
      end
      ADDIWB: regwrite_s = 1'b1;
      JEX: begin
        pcwrite = 1'b1;
        pcsrc   = 2'b10;
      end
      // PC already holds PC+4 here, so the link value is the current PC.
      JALEX: begin
        pcwrite    = 1'b1;
        pcsrc      = 2'b10;
        regwrite_s = 1'b1;
        regdst     = 2'b10;
        memtoreg   = 2'b10;
      end
      default: nxt_st = FETCH;
    endcase
  end

  // Reset suppresses every architectural write so an aborted instruction leaves no trace.
  assign pcen     = (pcwrite | (branch & zero)) & ~reset;
  assign irwrite  = irwrite_s  & ~reset;
  assign memwrite = memwrite_s & ~reset;
  assign regwrite = regwrite_s & ~reset;
  assign state    = cur_st;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Directed-sequence bench for the multicycle controller; expected output vectors
// are queued per cycle and compared against the DUT at the falling edge.
module tb_mips_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero;
  logic       pcen, iord, memwrite, irwrite, regwrite, alusrca;
  logic [1:0] regdst, memtoreg, alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  int n_checks = 0;
  int n_fails  = 0;
  logic [20:0] exp_q[$];

  logic [20:0] E_FETCH, E_FETCH_R, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB_LW, E_MEMWB_LBU,
               E_MEMWR, E_REX_SLT, E_REX_AND, E_REX_ADD, E_RWB, E_BEQ1, E_BEQ0,
               E_ADDIEX, E_ADDIWB, E_JEX, E_JAL, E_JAL_R;

  mips_multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
    .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .alucontrol(alucontrol), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [20:0] mk(input logic [3:0] s, input logic pe, input logic io,
                                     input logic mw, input logic ir, input logic rw,
                                     input logic [1:0] rd, input logic [1:0] mt,
                                     input logic a, input logic [1:0] b,
                                     input logic [1:0] pc, input logic [2:0] alu);
    return {s, pe, io, mw, ir, rw, rd, mt, a, b, pc, alu};
  endfunction

  task automatic step(input string tag, input logic [5:0] o, input logic [5:0] f,
                      input logic z, input logic r, input logic [20:0] e);
    logic [20:0] got, want;
    op = o; funct = f; zero = z; reset = r;
    exp_q.push_back(e);
    @(negedge clk);
    got  = {state, pcen, iord, memwrite, irwrite, regwrite, regdst, memtoreg,
            alusrca, alusrcb, pcsrc, alucontrol};
    want = exp_q.pop_front();
    n_checks++;
    assert (got === want)
      else begin
        n_fails++;
        $error("FAIL %s: observed st=%0d vec=%b expected st=%0d vec=%b",
               tag, got[20:17], got, want[20:17], want);
      end
    @(posedge clk);
    #1;
  endtask

  initial begin
    //               st    pe    io    mw    ir    rw    rd     mt     a     b      pc     alu
    E_FETCH     = mk(4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 2'b01, 2'b00, 3'b010);
    E_FETCH_R   = mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b01, 2'b00, 3'b010);
    E_DECODE    = mk(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b11, 2'b00, 3'b010);
    E_MEMADR    = mk(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b10, 2'b00, 3'b010);
    E_MEMRD     = mk(4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 3'b010);
    E_MEMWB_LW  = mk(4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 1'b0, 2'b00, 2'b00, 3'b010);
    E_MEMWB_LBU = mk(4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b11, 1'b0, 2'b00, 2'b00, 3'b010);
    E_MEMWR     = mk(4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 3'b010);
    E_REX_SLT   = mk(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 3'b111);
    E_REX_AND   = mk(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 3'b000);
    E_REX_ADD   = mk(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 3'b010);
    E_RWB       = mk(4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 3'b010);
    E_BEQ1      = mk(4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 2'b01, 3'b110);
    E_BEQ0      = mk(4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 2'b01, 3'b110);
    E_ADDIEX    = mk(4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b10, 2'b00, 3'b010);
    E_ADDIWB    = mk(4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 3'b010);
    E_JEX       = mk(4'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b10, 3'b010);
    E_JAL       = mk(4'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0, 2'b00, 2'b10, 3'b010);
    E_JAL_R     = mk(4'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 1'b0, 2'b00, 2'b10, 3'b010);

    // reset held two cycles, then first fetch
    step("rst0",      6'b100011, 6'b000000, 1'b0, 1'b1, E_FETCH_R);
    step("rst1",      6'b100011, 6'b000000, 1'b1, 1'b1, E_FETCH_R);
    step("fetch0",    6'b100011, 6'b000000, 1'b0, 1'b0, E_FETCH);
    // lw
    step("lw_dec",    6'b100011, 6'b000000, 1'b1, 1'b0, E_DECODE);
    step("lw_adr",    6'b100011, 6'b000000, 1'b0, 1'b0, E_MEMADR);
    step("lw_rd",     6'b100011, 6'b000000, 1'b0, 1'b0, E_MEMRD);
    step("lw_wb",     6'b100011, 6'b000000, 1'b0, 1'b0, E_MEMWB_LW);
    // lbu
    step("lbu_f",     6'b100100, 6'b000000, 1'b0, 1'b0, E_FETCH);
    step("lbu_dec",   6'b100100, 6'b000000, 1'b0, 1'b0, E_DECODE);
    step("lbu_adr",   6'b100100, 6'b000000, 1'b0, 1'b0, E_MEMADR);
    step("lbu_rd",    6'b100100, 6'b000000, 1'b0, 1'b0, E_MEMRD);
    step("lbu_wb",    6'b100100, 6'b000000, 1'b0, 1'b0, E_MEMWB_LBU);
    // sw
    step("sw_f",      6'b101011, 6'b000000, 1'b0, 1'b0, E_FETCH);
    step("sw_dec",    6'b101011, 6'b000000, 1'b0, 1'b0, E_DECODE);
    step("sw_adr",    6'b101011, 6'b000000, 1'b0, 1'b0, E_MEMADR);
    step("sw_wr",     6'b101011, 6'b000000, 1'b1, 1'b0, E_MEMWR);
    // beq taken / not taken
    step("beq1_f",    6'b000100, 6'b000000, 1'b0, 1'b0, E_FETCH);
    step("beq1_dec",  6'b000100, 6'b000000, 1'b0, 1'b0, E_DECODE);
    step("beq1_ex",   6'b000100, 6'b000000, 1'b1, 1'b0, E_BEQ1);
    step("beq0_f",    6'b000100, 6'b000000, 1'b0, 1'b0, E_FETCH);
    step("beq0_dec",  6'b000100, 6'b000000, 1'b0, 1'b0, E_DECODE);
    step("beq0_ex",   6'b000100, 6'b000000, 1'b0, 1'b0, E_BEQ0);
    // R-type: slt, and, unknown funct
    step("slt_f",     6'b000000, 6'b101010, 1'b0, 1'b0, E_FETCH);
    step("slt_dec",   6'b000000, 6'b101010, 1'b0, 1'b0, E_DECODE);
    step("slt_ex",    6'b000000, 6'b101010, 1'b1, 1'b0, E_REX_SLT);
    step("slt_wb",    6'b000000, 6'b101010, 1'b0, 1'b0, E_RWB);
    step("and_f",     6'b000000, 6'b100100, 1'b0, 1'b0, E_FETCH);
    step("and_dec",   6'b000000, 6'b100100, 1'b0, 1'b0, E_DECODE);
    step("and_ex",    6'b000000, 6'b100100, 1'b0, 1'b0, E_REX_AND);
    step("and_wb",    6'b000000, 6'b100100, 1'b0, 1'b0, E_RWB);
    step("badf_f",    6'b000000, 6'b111111, 1'b0, 1'b0, E_FETCH);
    step("badf_dec",  6'b000000, 6'b111111, 1'b0, 1'b0, E_DECODE);
    step("badf_ex",   6'b000000, 6'b111111, 1'b0, 1'b0, E_REX_ADD);
    step("badf_wb",   6'b000000, 6'b111111, 1'b0, 1'b0, E_RWB);
    // illegal opcode
    step("ill_f",     6'b111111, 6'b000000, 1'b0, 1'b0, E_FETCH);
    step("ill_dec",   6'b111111, 6'b000000, 1'b0, 1'b0, E_DECODE);
    // addi
    step("addi_f",    6'b001000, 6'b000000, 1'b0, 1'b0, E_FETCH);
    step("addi_dec",  6'b001000, 6'b000000, 1'b0, 1'b0, E_DECODE);
    step("addi_ex",   6'b001000, 6'b000000, 1'b1, 1'b0, E_ADDIEX);
    step("addi_wb",   6'b001000, 6'b000000, 1'b0, 1'b0, E_ADDIWB);
    // j
    step("j_f",       6'b000010, 6'b000000, 1'b0, 1'b0, E_FETCH);
    step("j_dec",     6'b000010, 6'b000000, 1'b0, 1'b0, E_DECODE);
    step("j_ex",      6'b000010, 6'b000000, 1'b0, 1'b0, E_JEX);
    // jal
    step("jal_f",     6'b000011, 6'b000000, 1'b0, 1'b0, E_FETCH);
    step("jal_dec",   6'b000011, 6'b000000, 1'b0, 1'b0, E_DECODE);
    step("jal_ex",    6'b000011, 6'b000000, 1'b0, 1'b0, E_JAL);
    // reset during JALEX gates its writes
    step("jalr_f",    6'b000011, 6'b000000, 1'b0, 1'b0, E_FETCH);
    step("jalr_dec",  6'b000011, 6'b000000, 1'b0, 1'b0, E_DECODE);
    step("jalr_ex",   6'b000011, 6'b000000, 1'b0, 1'b1, E_JAL_R);
    // reset during MEMRD of lw aborts it
    step("abt_f",     6'b100011, 6'b000000, 1'b0, 1'b0, E_FETCH);
    step("abt_dec",   6'b100011, 6'b000000, 1'b0, 1'b0, E_DECODE);
    step("abt_adr",   6'b100011, 6'b000000, 1'b0, 1'b0, E_MEMADR);
    step("abt_rd",    6'b100011, 6'b000000, 1'b0, 1'b1, E_MEMRD);
    step("abt_after", 6'b100011, 6'b000000, 1'b0, 1'b0, E_FETCH);
    step("abt_dec2",  6'b100011, 6'b000000, 1'b0, 1'b0, E_DECODE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
